// File: rtl/instruction_fetch_stage.sv
// instruction_fetch_stage: MIPS32 IF stage. Holds the PC, fetches from a
// variable-latency instruction memory, and owns the IF/ID pipeline register.
// Optional feature: define IF_DELAY_SLOT_EN for MIPS branch-delay-slot
// behaviour. Without it, a taken branch discards the in-flight/held word.
//
// Memory handshake: Imem_Req/Imem_Addr are asserted and held stable until the
// cycle in which Imem_Ready is high; that cycle delivers Imem_Rdata and
// completes the request. Imem_Req drops in HOLD and during the Reset cycle.
module instruction_fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP_WORD = 32'h0000_0000
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        PC_Enable,
  input  logic        IF_ID_Pipeline_Enable,
  input  logic        ID_Branch_Taken,
  input  logic [31:0] ID_Branch_Target,
  output logic        Imem_Req,
  output logic [31:0] Imem_Addr,
  input  logic        Imem_Ready,
  input  logic [31:0] Imem_Rdata,
  output logic [31:0] IF_ID_Instr,
  output logic [31:0] IF_ID_PC_Plus4,
  output logic        IF_ID_Valid,
  output logic        Fetch_Busy,
  output logic [1:0]  fsm_state
);

  typedef enum logic [1:0] {
    S_FETCH    = 2'd0,
    S_HOLD     = 2'd1,
    S_REDIRECT = 2'd2
  } state_t;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc_plus4;
    logic        valid;
  } ifid_t;

  localparam ifid_t IFID_BUBBLE = '{instr: NOP_WORD, pc_plus4: 32'h0, valid: 1'b0};

  state_t      state, state_nxt;
  logic [31:0] pc, pc_nxt;
  logic [31:0] hold_buf, hold_buf_nxt;
  logic [31:0] redir_tgt, redir_tgt_nxt;
  logic        redir_flag, redir_flag_nxt;
  ifid_t       ifid_q, ifid_d;
  logic        ifid_load;

  logic [31:0] pc_plus4;
  logic [31:0] branch_tgt;
  logic        adv;
  logic        taken;

  assign pc_plus4   = pc + 32'd4;
  assign branch_tgt = ID_Branch_Target & ~32'h3;
  assign adv        = PC_Enable & IF_ID_Pipeline_Enable;
  // A branch is only acted on when ID is actually moving forward.
  assign taken      = ID_Branch_Taken & IF_ID_Pipeline_Enable;

  assign Imem_Req       = !Reset && (state != S_HOLD);
  assign Imem_Addr      = pc;
  assign Fetch_Busy     = Imem_Req & !Imem_Ready;
  assign IF_ID_Instr    = ifid_q.instr;
  assign IF_ID_PC_Plus4 = ifid_q.pc_plus4;
  assign IF_ID_Valid    = ifid_q.valid;
  assign fsm_state      = state;

  // Next-state, PC and IF/ID update decisions; ifid_d defaults to a bubble.
  always_comb begin
    state_nxt      = state;
    pc_nxt         = pc;
    hold_buf_nxt   = hold_buf;
    redir_tgt_nxt  = redir_tgt;
    redir_flag_nxt = redir_flag;
    ifid_load      = 1'b0;
    ifid_d         = IFID_BUBBLE;
    unique case (state)
      S_FETCH: begin
        if (Imem_Ready) begin
`ifdef IF_DELAY_SLOT_EN
          if (adv) begin
            // Returning word is the delay slot when a branch is taken now.
            ifid_load = 1'b1;
            ifid_d    = '{instr: Imem_Rdata, pc_plus4: pc_plus4, valid: 1'b1};
            pc_nxt    = taken ? branch_tgt : pc_plus4;
          end else begin
            hold_buf_nxt = Imem_Rdata;
            state_nxt    = S_HOLD;
            ifid_load    = IF_ID_Pipeline_Enable;
            if (taken) begin
              redir_tgt_nxt  = branch_tgt;
              redir_flag_nxt = 1'b1;
            end
          end
`else
          if (taken) begin
            pc_nxt    = branch_tgt;
            ifid_load = 1'b1;
          end else if (adv) begin
            ifid_load = 1'b1;
            ifid_d    = '{instr: Imem_Rdata, pc_plus4: pc_plus4, valid: 1'b1};
            pc_nxt    = pc_plus4;
          end else begin
            hold_buf_nxt = Imem_Rdata;
            state_nxt    = S_HOLD;
            ifid_load    = IF_ID_Pipeline_Enable;
          end
`endif
        end else begin
          // Memory still busy: bubble into ID; a taken branch must wait for
          // the current request to finish, since the address cannot change.
          ifid_load = IF_ID_Pipeline_Enable;
          if (taken) begin
            redir_tgt_nxt  = branch_tgt;
            redir_flag_nxt = 1'b1;
            state_nxt      = S_REDIRECT;
          end
        end
      end
      S_HOLD: begin
`ifdef IF_DELAY_SLOT_EN
        if (adv) begin
          ifid_load      = 1'b1;
          ifid_d         = '{instr: hold_buf, pc_plus4: pc_plus4, valid: 1'b1};
          pc_nxt         = taken ? branch_tgt : (redir_flag ? redir_tgt : pc_plus4);
          redir_flag_nxt = 1'b0;
          state_nxt      = S_FETCH;
        end else begin
          ifid_load = IF_ID_Pipeline_Enable;
          if (taken) begin
            redir_tgt_nxt  = branch_tgt;
            redir_flag_nxt = 1'b1;
          end
        end
`else
        if (taken) begin
          pc_nxt    = branch_tgt;
          ifid_load = 1'b1;
          state_nxt = S_FETCH;
        end else if (adv) begin
          ifid_load = 1'b1;
          ifid_d    = '{instr: hold_buf, pc_plus4: pc_plus4, valid: 1'b1};
          pc_nxt    = pc_plus4;
          state_nxt = S_FETCH;
        end else begin
          ifid_load = IF_ID_Pipeline_Enable;
        end
`endif
      end
      S_REDIRECT: begin
`ifdef IF_DELAY_SLOT_EN
        if (Imem_Ready && adv) begin
          ifid_load      = 1'b1;
          ifid_d         = '{instr: Imem_Rdata, pc_plus4: pc_plus4, valid: 1'b1};
          pc_nxt         = redir_tgt;
          redir_flag_nxt = 1'b0;
          state_nxt      = S_FETCH;
        end else begin
          ifid_load = IF_ID_Pipeline_Enable;
          if (Imem_Ready) begin
            hold_buf_nxt = Imem_Rdata;
            state_nxt    = S_HOLD;
          end
        end
`else
        ifid_load = IF_ID_Pipeline_Enable;
        if (Imem_Ready) begin
          pc_nxt         = redir_tgt;
          redir_flag_nxt = 1'b0;
          state_nxt      = S_FETCH;
        end
`endif
      end
      default: begin
        state_nxt = S_FETCH;
      end
    endcase
  end

  // State, PC, buffers and IF/ID register with synchronous reset.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state      <= S_FETCH;
      pc         <= RESET_PC;
      hold_buf   <= 32'h0;
      redir_tgt  <= 32'h0;
      redir_flag <= 1'b0;
      ifid_q     <= IFID_BUBBLE;
    end else begin
      state      <= state_nxt;
      pc         <= pc_nxt;
      hold_buf   <= hold_buf_nxt;
      redir_tgt  <= redir_tgt_nxt;
      redir_flag <= redir_flag_nxt;
      if (ifid_load) begin
        ifid_q <= ifid_d;
      end
    end
  end

endmodule

// File: tb/tb_instruction_fetch_stage.sv
// tb_instruction_fetch_stage: directed stimulus with literal checks, plus a
// transaction-level model compared against the DUT on every falling edge.
module tb_instruction_fetch_stage;

  logic        clk;
  logic        rst;
  logic        pc_en;
  logic        ifid_en;
  logic        br_taken;
  logic [31:0] br_target;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic [31:0] imem_rdata;
  logic [31:0] ifid_instr;
  logic [31:0] ifid_pc4;
  logic        ifid_valid;
  logic        fetch_busy;
  logic [1:0]  dbg_state;

  int tests = 0;
  int fails = 0;

  // Model state: address being fetched, fetched words not yet handed to ID,
  // pending jump, and the expected IF/ID contents.
  logic [31:0] m_addr;
  logic [31:0] exp_q[$];
  logic        m_jump;
  logic [31:0] m_jtgt;
  logic [31:0] m_instr;
  logic [31:0] m_pc4;
  logic        m_valid;
  logic        m_known = 1'b0;

  instruction_fetch_stage dut (
    .Clk                   (clk),
    .Reset                 (rst),
    .PC_Enable             (pc_en),
    .IF_ID_Pipeline_Enable (ifid_en),
    .ID_Branch_Taken       (br_taken),
    .ID_Branch_Target      (br_target),
    .Imem_Req              (imem_req),
    .Imem_Addr             (imem_addr),
    .Imem_Ready            (imem_ready),
    .Imem_Rdata            (imem_rdata),
    .IF_ID_Instr           (ifid_instr),
    .IF_ID_PC_Plus4        (ifid_pc4),
    .IF_ID_Valid           (ifid_valid),
    .Fetch_Busy            (fetch_busy),
    .fsm_state             (dbg_state)
  );

  // Clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Instruction memory contents: distinct, nonzero per word address.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0] ^ 16'hC3C3, a[15:0]};
  endfunction

  assign imem_rdata = mem_word(imem_addr);

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic m_deliver(input logic [31:0] w);
    m_instr = w;
    m_pc4   = m_addr + 32'd4;
    m_valid = 1'b1;
  endtask

  task automatic m_bubble();
    m_instr = 32'h0;
    m_pc4   = 32'h0;
    m_valid = 1'b0;
  endtask

  // Advance the model by one clock edge using the inputs present now.
  task automatic model_step();
    logic [31:0] tgt;
    logic        adv, taken, got;
    if (rst) begin
      m_addr  = 32'h0;
      exp_q.delete();
      m_jump  = 1'b0;
      m_jtgt  = 32'h0;
      m_bubble();
      m_known = 1'b1;
      return;
    end
    tgt   = {br_target[31:2], 2'b00};
    adv   = pc_en && ifid_en;
    taken = br_taken && ifid_en;
    got   = (exp_q.size() == 0) && imem_ready;
`ifdef IF_DELAY_SLOT_EN
    if (got) exp_q.push_back(mem_word(m_addr));
    if (taken) begin
      m_jump = 1'b1;
      m_jtgt = tgt;
    end
    if (exp_q.size() != 0 && adv) begin
      m_deliver(exp_q.pop_front());
      m_addr = m_jump ? m_jtgt : m_addr + 32'd4;
      m_jump = 1'b0;
    end else if (ifid_en) begin
      m_bubble();
    end
`else
    if (m_jump) begin
      if (got) begin
        m_addr = m_jtgt;
        m_jump = 1'b0;
      end
      if (ifid_en) m_bubble();
    end else if (taken) begin
      if (exp_q.size() == 0 && !imem_ready) begin
        m_jump = 1'b1;
        m_jtgt = tgt;
      end else begin
        exp_q.delete();
        m_addr = tgt;
      end
      m_bubble();
    end else begin
      if (got) exp_q.push_back(mem_word(m_addr));
      if (exp_q.size() != 0 && adv) begin
        m_deliver(exp_q.pop_front());
        m_addr = m_addr + 32'd4;
      end else if (ifid_en) begin
        m_bubble();
      end
    end
`endif
  endtask

  // Scoreboard: compare DUT against model mid-cycle, then step the model.
  always @(negedge clk) begin
    logic exp_req;
    if (m_known) begin
      exp_req = !rst && (exp_q.size() == 0);
      check("m_req", {31'h0, imem_req}, {31'h0, exp_req});
      if (exp_req) check("m_addr", imem_addr, m_addr);
      check("m_busy", {31'h0, fetch_busy}, {31'h0, exp_req && !imem_ready});
      check("m_instr", ifid_instr, m_instr);
      check("m_pc4", ifid_pc4, m_pc4);
      check("m_valid", {31'h0, ifid_valid}, {31'h0, m_valid});
    end
    model_step();
  end

  // Driver: apply one cycle of inputs, return 1 time unit after the edge.
  task automatic drive(input logic r, input logic pe, input logic ie,
                       input logic rdy, input logic tk, input logic [31:0] tg);
    rst        = r;
    pc_en      = pe;
    ifid_en    = ie;
    imem_ready = rdy;
    br_taken   = tk;
    br_target  = tg;
    @(posedge clk);
    #1;
  endtask

  // Directed stimulus with hand-computed literal expectations.
  initial begin
    drive(1, 1, 1, 0, 0, 0);
    drive(1, 1, 1, 0, 0, 0);
    check("rst_req", {31'h0, imem_req}, 32'h0);
    check("rst_valid", {31'h0, ifid_valid}, 32'h0);
    check("rst_pc4", ifid_pc4, 32'h0);
    check("rst_addr", imem_addr, 32'h0);

    // Zero-wait stream from RESET_PC.
    for (int k = 1; k <= 4; k++) begin
      drive(0, 1, 1, 1, 0, 0);
      check("seq_pc4", ifid_pc4, 32'(4 * k));
      check("seq_addr", imem_addr, 32'(4 * k));
      check("seq_valid", {31'h0, ifid_valid}, 32'h1);
    end
    check("seq_instr", ifid_instr, 32'hC3CF_000C);

    // Full stall with memory ready at 0x10.
    for (int k = 0; k < 3; k++) begin
      drive(0, 0, 0, 1, 0, 0);
      check("hold_req", {31'h0, imem_req}, 32'h0);
      check("hold_pc4", ifid_pc4, 32'h10);
      check("hold_instr", ifid_instr, 32'hC3CF_000C);
    end
    drive(0, 1, 1, 0, 0, 0);
    check("rel_instr", ifid_instr, 32'hC3D3_0010);
    check("rel_pc4", ifid_pc4, 32'h14);
    check("rel_addr", imem_addr, 32'h14);

    // Two wait states at 0x14.
    for (int k = 0; k < 2; k++) begin
      drive(0, 1, 1, 0, 0, 0);
      check("slow_addr", imem_addr, 32'h14);
      check("slow_instr", ifid_instr, 32'h0);
      check("slow_valid", {31'h0, ifid_valid}, 32'h0);
      check("slow_busy", {31'h0, fetch_busy}, 32'h1);
    end
    drive(0, 1, 1, 1, 0, 0);
    check("slow_done", ifid_instr, 32'hC3D7_0014);
    check("slow_pc4", ifid_pc4, 32'h18);
    drive(0, 1, 1, 1, 0, 0);
    drive(0, 1, 1, 1, 0, 0);
    check("pre_br_addr", imem_addr, 32'h20);

    // Taken branch to 0x100 while the request at 0x20 is pending.
    drive(0, 1, 1, 0, 1, 32'h100);
    check("br_valid", {31'h0, ifid_valid}, 32'h0);
    check("br_addr0", imem_addr, 32'h20);
    drive(0, 1, 1, 0, 0, 0);
    check("br_addr1", imem_addr, 32'h20);
    drive(0, 1, 1, 1, 0, 0);
    check("br_tgt_addr", imem_addr, 32'h100);
`ifdef IF_DELAY_SLOT_EN
    check("br_slot_valid", {31'h0, ifid_valid}, 32'h1);
    check("br_slot_instr", ifid_instr, 32'hC3E3_0020);
    check("br_slot_pc4", ifid_pc4, 32'h24);
`else
    check("br_flush_valid", {31'h0, ifid_valid}, 32'h0);
`endif
    drive(0, 1, 1, 1, 0, 0);
    check("br_tgt_instr", ifid_instr, 32'hC2C3_0100);
    check("br_tgt_pc4", ifid_pc4, 32'h104);

    // Taken branch with ready at 0x104; target low bits must be cleared.
    drive(0, 1, 1, 1, 1, 32'h203);
    check("brr_addr", imem_addr, 32'h200);
`ifdef IF_DELAY_SLOT_EN
    check("brr_slot", ifid_instr, 32'hC2C7_0104);
`else
    check("brr_valid", {31'h0, ifid_valid}, 32'h0);
`endif

    // Branch arriving while a fetched word is held.
    drive(0, 0, 0, 1, 0, 0);
    drive(0, 0, 1, 0, 1, 32'h300);
    check("hbr_valid", {31'h0, ifid_valid}, 32'h0);
    drive(0, 1, 1, 1, 0, 0);
`ifdef IF_DELAY_SLOT_EN
    check("hbr_instr", ifid_instr, 32'hC1C3_0200);
    check("hbr_addr", imem_addr, 32'h300);
`else
    check("hbr_instr", ifid_instr, 32'hC0C3_0300);
    check("hbr_addr", imem_addr, 32'h304);
`endif

    // PC wrap at the top of the address space.
    drive(0, 1, 1, 1, 1, 32'hFFFF_FFFC);
    check("wrap_pre", imem_addr, 32'hFFFF_FFFC);
    drive(0, 1, 1, 1, 0, 0);
    check("wrap_instr", ifid_instr, 32'h3C3F_FFFC);
    check("wrap_pc4", ifid_pc4, 32'h0);
    check("wrap_addr", imem_addr, 32'h0);

    // Reset during an outstanding request, with a late ready in reset cycle.
    drive(0, 1, 1, 1, 0, 0);
    drive(0, 1, 1, 0, 0, 0);
    check("mid_addr", imem_addr, 32'h4);
    drive(1, 1, 1, 1, 0, 0);
    check("mid_rst_req", {31'h0, imem_req}, 32'h0);
    check("mid_rst_addr", imem_addr, 32'h0);
    check("mid_rst_valid", {31'h0, ifid_valid}, 32'h0);
    check("mid_rst_instr", ifid_instr, 32'h0);
    drive(0, 1, 1, 1, 0, 0);
    check("post_rst_instr", ifid_instr, 32'hC3C3_0000);
    check("post_rst_pc4", ifid_pc4, 32'h4);
    drive(0, 1, 1, 1, 0, 0);
    drive(0, 1, 1, 0, 0, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/instruction_fetch_stage.md
# instruction_fetch_stage

Instruction-fetch stage of the MIPS32 pipeline: holds the PC, issues requests to a variable-latency instruction memory, and owns the IF/ID pipeline register. It consumes the stall controls produced by the hazard handling unit (PC_Enable, IF_ID_Pipeline_Enable) and the branch decision resolved in ID. It feeds ID with the instruction, PC+4 and a valid bit, inserting bubbles when memory is slow and flushing on taken branches.

## Interface
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- NOP_WORD, 32'h0000_0000, instruction word driven into IF/ID for bubbles and flushes.

- Clk  in  1  rising-edge clock.
- Reset  in  1  synchronous, active-high reset.
- PC_Enable  in  1  hazard unit; 0 = hold PC.
- IF_ID_Pipeline_Enable  in  1  hazard unit; 0 = hold IF/ID register.
- ID_Branch_Taken  in  1  branch in ID resolved taken; ignored while IF_ID_Pipeline_Enable=0.
- ID_Branch_Target  in  32  branch target; bits [1:0] forced to 0.
- Imem_Req  out  1  fetch request.
- Imem_Addr  out  32  fetch address, word aligned.
- Imem_Ready  in  1  read data valid this cycle; completes the request.
- Imem_Rdata  in  32  instruction word.
- IF_ID_Instr  out  32  registered instruction to ID.
- IF_ID_PC_Plus4  out  32  registered PC+4 of that instruction.
- IF_ID_Valid  out  1  1 = real instruction, 0 = bubble.
- Fetch_Busy  out  1  request outstanding and not ready this cycle.

## Operation
- Registers: PC, state, hold buffer (32b), redirect target (32b), redirect flag, IF/ID {Instr, PC_Plus4, Valid}.
- Advance condition ADV = PC_Enable & IF_ID_Pipeline_Enable.
- Priority: Reset > ID_Branch_Taken (qualified) > ADV/stall.
- States:
  - FETCH: Imem_Req=1, Imem_Addr=PC.
    - Imem_Ready & taken: discard Rdata, PC←target, flush IF/ID, stay FETCH.
    - Imem_Ready & ADV: IF/ID←{Rdata, PC+4, 1}, PC←PC+4.
    - Imem_Ready & !ADV: buffer←Rdata, go HOLD.
    - !Imem_Ready & taken: save target, flush IF/ID, go REDIRECT.
    - !Imem_Ready & IF_ID_Pipeline_Enable: IF/ID←{NOP_WORD, 0, 0} (bubble).
  - HOLD: Imem_Req=0. Taken: discard buffer, PC←target, flush, go FETCH. ADV: IF/ID←{buffer, PC+4, 1}, PC←PC+4, go FETCH.
  - REDIRECT: Imem_Req=1 at old PC (address never changes mid-request). Imem_Ready: discard Rdata, PC←saved target, go FETCH. Bubbles inserted while IF_ID_Pipeline_Enable=1.
- Flush = IF/ID←{NOP_WORD, 32'h0, 0}.
- PC+4 wraps modulo 2^32 (32'hFFFF_FFFC → 32'h0000_0000).
- IF/ID holds its value whenever IF_ID_Pipeline_Enable=0 and no flush applies.

## Timing
- Reset values: PC=RESET_PC, state=FETCH, IF_ID_Instr=NOP_WORD, IF_ID_PC_Plus4=0, IF_ID_Valid=0, redirect flag=0; Imem_Req=0 during the reset cycle.
- First request: cycle after Reset deasserts, Imem_Addr=RESET_PC.
- Zero-wait memory (Imem_Ready same cycle as Imem_Req): one instruction per cycle; IF/ID updates on the edge ending the ready cycle.
- Imem_Req and Imem_Addr stable from assertion until the Imem_Ready cycle inclusive.
- Taken branch: first fetch at target starts the cycle after the redirect is resolved (FETCH/HOLD) or the cycle after the old request completes (REDIRECT).
- Reset mid-request: state aborted; a late Imem_Ready after reset is ignored only if it arrives during the reset cycle; memory must drop outstanding requests on Reset.
- Fetch_Busy = Imem_Req & !Imem_Ready.

## Configuration
- IF_DELAY_SLOT_EN defined: MIPS branch delay slot. A taken branch does not discard or flush the instruction currently being fetched/held; it is delivered to IF/ID normally (subject to ADV), and the following PC is the target instead of PC+4. REDIRECT delivers its returning word as the delay slot and then jumps.
- Not defined: taken branch discards the in-flight/held instruction and flushes IF/ID as specified above.

## Test plan
- Reset release, Imem_Ready=1 always, RESET_PC=0 -> Imem_Addr 0,4,8,...; IF_ID_PC_Plus4 4,8,12 one per cycle; Valid=1 from cycle 2.
- Imem_Ready low 2 cycles per request -> Imem_Addr stable 3 cycles; two bubble cycles (Instr=0, Valid=0) between instructions.
- PC_Enable=IF_ID_Pipeline_Enable=0 for 3 cycles while Imem_Ready=1 at 0x10 -> HOLD, Imem_Req=0, IF/ID unchanged; on release IF_ID_Instr=word@0x10, PC_Plus4=0x14.
- ID_Branch_Taken, target 0x100, request at 0x20 pending -> IF/ID flushed, Imem_Addr stays 0x20 until ready, next Imem_Addr=0x100; with IF_DELAY_SLOT_EN word@0x20 delivered Valid=1 before target word.
- PC=0xFFFF_FFFC, ADV -> next Imem_Addr=0x0000_0000, IF_ID_PC_Plus4=0.
